seq_mult: RTL
=============

# seq_mult

Sequential unsigned N×N shift-and-add multiplier that time-shares a single N-bit `add` ripple-carry instance across N iterations. The block is the sequencing controller for the lab adder datapath. It holds the operands, steps an FSM and iteration counter, and feeds the adder one partial product per cycle. It produces a 2N-bit product with a start/busy/done handshake, for use by the lab's top-level display and test logic.

## Interface
- `N`, default 4, operand width in bits; legal range 2..16; the internal adder is instantiated as `add #(N)`.
- `clk`  in  1  rising-edge clock, the only clock in the block.
- `rst_n`  in  1  asynchronous, active-low reset; every flop resets immediately on the falling edge of `rst_n`.
- `start`  in  1  request to begin a multiply; sampled on a rising edge only while the FSM is in IDLE.
- `a`  in  N  multiplicand; sampled on the accepting edge only.
- `b`  in  N  multiplier; sampled on the accepting edge only.
- `busy`  out  1  high in RUN and DONE; reset value 0.
- `done`  out  1  one-cycle pulse marking that `product` is valid; reset value 0.
- `product`  out  2N  registered result; reset value 0; holds its value until the next completion.

## Operation
- Registers:
  - `mcand[N-1:0]`
  - `acc[N-1:0]` (upper half)
  - `mq[N-1:0]` (lower half; multiplier bits shift out of it)
  - `cnt`, width $clog2(N)+1
  - `state`
- FSM states and transitions:
  - IDLE: if `start`=1 then `mcand`←a, `mq`←b, `acc`←0, `cnt`←0, go to RUN; otherwise stay in IDLE.
  - RUN: one iteration per edge, as follows:
    - Adder inputs are `acc` and (`mq[0]` ? `mcand` : 0); the adder produces `{Cout,sum}`.
    - `{acc,mq}` ← `{Cout,sum,mq[N-1:1]}`, i.e. a logical right shift that carries the adder carry into the top bit.
    - `cnt`←`cnt`+1.
    - On the iteration where `cnt`==N-1 (the Nth), also load `product`←the shifted `{acc,mq}` value, then go to DONE.
  - DONE: `done`=1 for this single cycle, then go to IDLE unconditionally.
- Arithmetic: unsigned only. The result is exact, since an N×N product always fits in 2N bits, so there is no overflow case. The adder's `Cout` must be captured every iteration and must never be dropped.
- `start` in RUN or DONE is ignored. It is not queued; a requester must re-assert `start` once `busy`=0.
- `a` and `b` may change freely after the accepting edge; they do not affect an operation in progress.
- `product` is not cleared when a new operation starts; it updates only on the completing edge.
- Reset mid-operation: the FSM returns to IDLE and all outputs go to 0. No `done` pulse is produced for the aborted operation.
- Illegal or unreachable state encodings go to IDLE on the next edge.

## Timing
- Let edge E0 be the edge that accepts `start`.
- `busy` rises after E0.
- The iterations occur on edges E1..EN; `product` becomes valid after EN.
- `done`=1 for exactly one cycle, between EN and EN+1.
- `busy` falls after EN+1.
- Latency from the accepting edge to `done` is N edges. The minimum start-to-start spacing is N+2 edges, since a new `start` is accepted at EN+2 at the earliest.
- The critical path is one N-bit ripple through the adder plus a 2:1 mux; no other logic sits in that path.

## Configuration
- Macro `SEQ_MULT_ZERO_SKIP_EN`.
- Defined: if `a`==0 or `b`==0 on the accepting edge, the FSM goes directly IDLE→DONE and `product`←0 on E0. `done` is then high between E0 and E1 (latency 1) and `busy` is high for that one cycle.
- Undefined: zero operands take the full N-iteration path, so latency is always N.
- Nonzero operands behave identically in both builds.

## Test plan
- N=4, reset then `a`=3, `b`=5, `start` for one cycle -> `done` pulses exactly 4 edges after acceptance, `product`=15, `busy` high for 5 cycles.
- N=4, `a`=15, `b`=15 -> `product`=225 (8'hE1); this exercises `Cout` propagation into `acc`.
- N=8, exhaustive sweep of all 65,536 operand pairs against a reference model, with back-to-back starts at the minimum spacing of N+2 -> every `product` matches the model and every operation produces exactly one `done`.
- N=4, `start` held high throughout an operation with `a` and `b` changing every cycle -> only the first operands are used, and the next operation begins at E6.
- N=4, `rst_n` pulled low asynchronously at E2 of a 9×7 multiply -> `busy`, `done` and `product` read 0 immediately, and no `done` follows after reset is released.
- `a`=0, `b`=9: with `SEQ_MULT_ZERO_SKIP_EN` defined -> `done` pulses 1 edge after acceptance and `product`=0; without it -> `done` pulses after 4 edges and `product`=0.

Source files
------------

// File: rtl/seq_mult_if.sv
// Start/busy/done handshake bundle for seq_mult: operands in, 2N-bit product out.
interface seq_mult_if #(parameter int N = 4);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult.sv
// Sequential unsigned NxN shift-and-add multiplier time-sharing one add #(N) ripple-carry adder.
// Build option SEQ_MULT_ZERO_SKIP_EN: zero operands go straight IDLE->DONE with product 0.
module add #(parameter int N = 4) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;

  assign c[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign cout = c[N];
endmodule

module seq_mult #(parameter int N = 4) (
  input  logic     clk,
  input  logic     rst_n,
  seq_mult_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   mcand, acc, mq, addend, sum;
  logic           cout;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] shifted, product;
  logic           load, step, fin;
`ifdef SEQ_MULT_ZERO_SKIP_EN
  logic           zskip;
`endif

  // Single adder + operand mux is the whole critical path.
  assign addend  = mq[0] ? mcand : '0;
  add #(N) u_add (.x(acc), .y(addend), .sum(sum), .cout(cout));
  assign shifted = {cout, sum, mq[N-1:1]};

  always_comb begin
    state_nxt = IDLE;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
`ifdef SEQ_MULT_ZERO_SKIP_EN
    zskip     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          load = 1'b1;
`ifdef SEQ_MULT_ZERO_SKIP_EN
          if (bus.a == '0 || bus.b == '0) begin
            zskip     = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
          end
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(N - 1)) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        mcand <= bus.a;
        mq    <= bus.b;
        acc   <= '0;
        cnt   <= '0;
      end
      // Carry out lands in the top accumulator bit as the pair shifts right.
      if (step) begin
        {acc, mq} <= shifted;
        cnt       <= cnt + CW'(1);
      end
      if (fin) product <= shifted;
`ifdef SEQ_MULT_ZERO_SKIP_EN
      if (zskip) product <= '0;
`endif
    end
  end

  assign bus.busy    = (state == RUN) || (state == DONE);
  assign bus.done    = (state == DONE);
  assign bus.product = product;
endmodule
